// File: rtl/ahb_lite_pattern_tester_pkg.sv
// Shared definitions for the AHB-Lite SDRAM pattern tester: FSM states,
// bus encodings, pattern modes and the pattern multiplier.
package ahb_lite_pattern_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WDRAIN = 3'd2,
        ST_WAIT   = 3'd3,
        ST_READ   = 3'd4,
        ST_RDRAIN = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'd0,
        MODE_NADDR = 2'd1,
        MODE_HASH  = 2'd2,
        MODE_WALK1 = 2'd3
    } mode_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;

    // Golden-ratio constant spreads consecutive indices across all bits.
    localparam logic [31:0] PATTERN_MULT  = 32'h9E37_79B9;

endpackage

// File: rtl/ahb_lite_pattern_tester_if.sv
// AHB-Lite bus bundle between the pattern tester (master) and the system bus.
interface ahb_lite_pattern_tester_if;

    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_lite_pattern_gen.sv
// Combinational test-pattern generator: the word expected at a given sweep
// index/address depends only on mode, index, address and the seed.
module ahb_lite_pattern_gen
    import ahb_lite_pattern_tester_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  mode_t       mode,
    input  logic [31:0] idx,
    input  logic [31:0] addr,
    output logic [31:0] data
);

    // Select the pattern word for this index/address.
    always_comb begin
        data = addr;
        case (mode)
            MODE_ADDR:  data = addr;
            MODE_NADDR: data = ~addr;
            MODE_HASH:  data = (idx * PATTERN_MULT) + SEED;
            MODE_WALK1: data = 32'h1 << idx[4:0];
            default:    data = addr;
        endcase
    end

endmodule

// File: rtl/ahb_lite_pattern_tester.sv
// AHB-Lite bus master for SDRAM bring-up: writes a pattern sweep, waits,
// then reads it back PASS_CNT times, counting mismatches and ERROR responses.
// Address and data phases are pipelined back to back.
module ahb_lite_pattern_tester
    import ahb_lite_pattern_tester_pkg::*;
#(
    parameter logic [31:0] ADDR_INCREMENT = 32'h4,
    parameter int unsigned WORD_CNT       = 256,
    parameter int unsigned DELAY_BITS     = 10,
    parameter int unsigned PASS_CNT       = 2,
    parameter logic [31:0] SEED           = 32'hA5A5_0000
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    ahb_lite_pattern_tester_if.master bus,
    input  logic                      START,
    input  logic [1:0]                MODE,
    input  logic [31:0]               STARTADDR,
    output logic [31:0]               ERRCOUNT,
    output logic [7:0]                CHKCOUNT,
    output logic [31:0]               FIRSTERR_ADDR,
    output logic [31:0]               FIRSTERR_DATA,
    output logic                      S_BUSY,
    output logic                      S_WRITE,
    output logic                      S_CHECK,
    output logic                      S_SUCCESS,
    output logic                      S_FAILED
);

    localparam logic [31:0] LAST_IDX = 32'(WORD_CNT - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    state_t                state_q, state_d;
    mode_t                 mode_q, mode_d;
    logic [31:0]           base_q, base_d;
    logic [31:0]           haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [31:0]           hwdata_q, hwdata_d;
    logic [31:0]           aidx_q, aidx_d;
    logic                  dp_vld_q, dp_vld_d;
    logic                  dp_write_q, dp_write_d;
    logic [31:0]           dp_idx_q, dp_idx_d;
    logic [31:0]           dp_addr_q, dp_addr_d;
    logic [DELAY_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]           errcount_q, errcount_d;
    logic [7:0]            chkcount_q, chkcount_d;
    logic [31:0]           ferr_addr_q, ferr_addr_d;
    logic [31:0]           ferr_data_q, ferr_data_d;

    logic [31:0] wr_pat;
    logic [31:0] rd_exp;
    logic        a_accept;
    logic        d_done;
    logic        last_addr;
    logic        phase_err;
    logic [7:0]  chk_next;

    // Write data for the index currently in its address phase.
    ahb_lite_pattern_gen #(.SEED(SEED)) u_wr_gen (
        .mode (mode_q),
        .idx  (aidx_q),
        .addr (haddr_q),
        .data (wr_pat)
    );

    // Expected read data for the index currently in its data phase.
    ahb_lite_pattern_gen #(.SEED(SEED)) u_rd_gen (
        .mode (mode_q),
        .idx  (dp_idx_q),
        .addr (dp_addr_q),
        .data (rd_exp)
    );

    // Next-state, bus pipeline, error checking and counters.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        aidx_d      = aidx_q;
        dp_vld_d    = dp_vld_q;
        dp_write_d  = dp_write_q;
        dp_idx_d    = dp_idx_q;
        dp_addr_d   = dp_addr_q;
        wait_cnt_d  = wait_cnt_q;
        errcount_d  = errcount_q;
        chkcount_d  = chkcount_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;

        a_accept  = bus.HREADY && (htrans_q == HTRANS_NONSEQ);
        d_done    = bus.HREADY && dp_vld_q;
        last_addr = (aidx_q == LAST_IDX);
        chk_next  = chkcount_q + 8'd1;

        // An accepted address phase becomes the next data phase; a stall
        // (HREADY low) leaves the whole pipeline untouched.
        if (bus.HREADY) begin
            dp_vld_d = a_accept;
            if (a_accept) begin
                dp_write_d = hwrite_q;
                dp_idx_d   = aidx_q;
                dp_addr_d  = haddr_q;
                if (hwrite_q) begin
                    hwdata_d = wr_pat;
                end
            end
        end

        phase_err = 1'b0;
        if (d_done) begin
            phase_err = bus.HRESP || (!dp_write_q && (bus.HRDATA != rd_exp));
        end
        if (phase_err) begin
            errcount_d = sat_inc(errcount_q);
            if (errcount_q == 32'd0) begin
                ferr_addr_d = dp_addr_q;
                ferr_data_d = bus.HRDATA;
            end
        end

        // The final address phase hands the bus back to IDLE.
        if (a_accept) begin
            if (last_addr) begin
                htrans_d = HTRANS_IDLE;
                hwrite_d = 1'b0;
            end else begin
                aidx_d  = aidx_q + 32'd1;
                haddr_d = haddr_q + ADDR_INCREMENT;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d     = ST_WRITE;
                    mode_d      = mode_t'(MODE);
                    base_d      = STARTADDR;
                    errcount_d  = 32'd0;
                    chkcount_d  = 8'd0;
                    ferr_addr_d = 32'd0;
                    ferr_data_d = 32'd0;
                    haddr_d     = STARTADDR;
                    htrans_d    = HTRANS_NONSEQ;
                    hwrite_d    = 1'b1;
                    aidx_d      = 32'd0;
                end
            end
            ST_WRITE: begin
                if (a_accept && last_addr) begin
                    state_d = ST_WDRAIN;
                end
            end
            ST_WDRAIN: begin
                if (d_done) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (&wait_cnt_q) begin
                    state_d  = ST_READ;
                    haddr_d  = base_q;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = 1'b0;
                    aidx_d   = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + DELAY_BITS'(1);
                end
            end
            ST_READ: begin
                if (a_accept && last_addr) begin
                    state_d = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                if (d_done) begin
                    chkcount_d = chk_next;
                    if ({24'd0, chk_next} >= 32'(PASS_CNT)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ADDR;
            base_q      <= 32'd0;
            haddr_q     <= 32'd0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'd0;
            aidx_q      <= 32'd0;
            dp_vld_q    <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_idx_q    <= 32'd0;
            dp_addr_q   <= 32'd0;
            wait_cnt_q  <= '0;
            errcount_q  <= 32'd0;
            chkcount_q  <= 8'd0;
            ferr_addr_q <= 32'd0;
            ferr_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            aidx_q      <= aidx_d;
            dp_vld_q    <= dp_vld_d;
            dp_write_q  <= dp_write_d;
            dp_idx_q    <= dp_idx_d;
            dp_addr_q   <= dp_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            errcount_q  <= errcount_d;
            chkcount_q  <= chkcount_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
        end
    end

    assign bus.HADDR  = haddr_q;
    assign bus.HBURST = HBURST_SINGLE;
    assign bus.HSEL   = 1'b1;
    assign bus.HSIZE  = HSIZE_WORD;
    assign bus.HTRANS = htrans_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HWDATA = hwdata_q;

    assign ERRCOUNT      = errcount_q;
    assign CHKCOUNT      = chkcount_q;
    assign FIRSTERR_ADDR = ferr_addr_q;
    assign FIRSTERR_DATA = ferr_data_q;

    assign S_BUSY    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign S_WRITE   = (state_q == ST_WRITE) || (state_q == ST_WDRAIN);
    assign S_CHECK   = (state_q == ST_WAIT) || (state_q == ST_READ) || (state_q == ST_RDRAIN);
    assign S_SUCCESS = (state_q == ST_DONE) && (errcount_q == 32'd0);
    assign S_FAILED  = (state_q == ST_DONE) && (errcount_q != 32'd0);

endmodule

// File: tb/tb_ahb_lite_pattern_tester.sv
// Directed bench for ahb_lite_pattern_tester with a small zero/random-wait
// SDRAM slave model that can corrupt reads and return ERROR on a write.
module tb_ahb_lite_pattern_tester;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        START;
    logic [1:0]  MODE;
    logic [31:0] STARTADDR;
    logic [31:0] ERRCOUNT;
    logic [7:0]  CHKCOUNT;
    logic [31:0] FIRSTERR_ADDR;
    logic [31:0] FIRSTERR_DATA;
    logic        S_BUSY, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED;

    ahb_lite_pattern_tester_if bus();

    ahb_lite_pattern_tester #(
        .ADDR_INCREMENT (32'h4),
        .WORD_CNT       (8),
        .DELAY_BITS     (3),
        .PASS_CNT       (2),
        .SEED           (32'hA5A5_0000)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .bus           (bus),
        .START         (START),
        .MODE          (MODE),
        .STARTADDR     (STARTADDR),
        .ERRCOUNT      (ERRCOUNT),
        .CHKCOUNT      (CHKCOUNT),
        .FIRSTERR_ADDR (FIRSTERR_ADDR),
        .FIRSTERR_DATA (FIRSTERR_DATA),
        .S_BUSY        (S_BUSY),
        .S_WRITE       (S_WRITE),
        .S_CHECK       (S_CHECK),
        .S_SUCCESS     (S_SUCCESS),
        .S_FAILED      (S_FAILED)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:63];
    logic        s_vld;
    logic        s_write;
    logic [31:0] s_addr;
    int          wr_done = 0;
    int          corrupt_served = 0;
    logic [31:0] wlog_addr [0:127];
    logic [31:0] wlog_data [0:127];

    int          stall_pct;
    int          resp_at;
    int          corrupt_req;
    logic [31:0] corrupt_addr;
    logic        corrupt_hit;

    assign corrupt_hit = (corrupt_req > corrupt_served) && s_vld && !s_write &&
                         (s_addr == corrupt_addr);

    // Track the data phase and commit writes when it completes.
    always @(posedge HCLK) begin
        if (HRESET) begin
            s_vld <= 1'b0;
        end else if (bus.HREADY) begin
            if (s_vld && s_write) begin
                if (!bus.HRESP) mem[s_addr[7:2]] <= bus.HWDATA;
                wlog_addr[wr_done % 128] <= s_addr;
                wlog_data[wr_done % 128] <= bus.HWDATA;
                wr_done <= wr_done + 1;
            end
            if (corrupt_hit) corrupt_served <= corrupt_served + 1;
            s_vld   <= (bus.HTRANS == 2'b10);
            s_addr  <= bus.HADDR;
            s_write <= bus.HWRITE;
        end
    end

    // Drive slave responses away from the sampling edge.
    always @(negedge HCLK) begin
        if (stall_pct == 0) bus.HREADY = 1'b1;
        else                bus.HREADY = (int'($urandom_range(99)) >= stall_pct);
        bus.HRESP = s_vld && s_write && (wr_done == resp_at);
        if (s_vld && !s_write) bus.HRDATA = corrupt_hit ? 32'h0 : mem[s_addr[7:2]];
        else                   bus.HRDATA = 32'hDEAD_BEEF;
    end

    // Snapshot of the bus in a stalled cycle, compared one half-cycle later.
    logic        snap_vld = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic [1:0]  snap_trans;
    always @(posedge HCLK) begin
        snap_vld   <= !HRESET && (bus.HREADY === 1'b0) && ((bus.HTRANS == 2'b10) || s_vld);
        snap_addr  <= bus.HADDR;
        snap_wdata <= bus.HWDATA;
        snap_trans <= bus.HTRANS;
    end

    // ---------------- checking ----------------
    int total;
    int bad;
    int wcyc, ccyc, stall_seen, base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_test(input logic [1:0] m, input logic [31:0] a);
        @(negedge HCLK);
        START = 1'b1;
        MODE = m;
        STARTADDR = a;
        @(negedge HCLK);
        START = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input int poke_at);
        int n;
        n = 0;
        wcyc = 0;
        ccyc = 0;
        while (!(S_SUCCESS || S_FAILED) && n < budget) begin
            if (snap_vld) begin
                stall_seen++;
                chk("stall_haddr", bus.HADDR, snap_addr);
                chk("stall_hwdata", bus.HWDATA, snap_wdata);
                chk("stall_htrans", 32'(bus.HTRANS), 32'(snap_trans));
            end
            if (S_WRITE) wcyc++;
            if (S_CHECK) ccyc++;
            if (n == poke_at) begin
                START = 1'b1;
                MODE = 2'd3;
            end else begin
                START = 1'b0;
            end
            @(negedge HCLK);
            n++;
        end
        START = 1'b0;
        chk("done_reached", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int found;
        total = 0;
        bad = 0;
        stall_seen = 0;
        START = 1'b0;
        MODE = 2'd0;
        STARTADDR = 32'd0;
        stall_pct = 0;
        resp_at = -1;
        corrupt_req = 0;
        corrupt_addr = 32'd0;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);

        // Reset state
        chk("rst_haddr", bus.HADDR, 32'd0);
        chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_errcount", ERRCOUNT, 32'd0);
        chk("rst_chkcount", 32'(CHKCOUNT), 32'd0);
        chk("rst_ferr_addr", FIRSTERR_ADDR, 32'd0);
        chk("rst_ferr_data", FIRSTERR_DATA, 32'd0);
        chk("rst_flags", 32'({S_BUSY, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED}), 32'd0);
        chk("const_hsel", 32'(bus.HSEL), 32'd1);
        chk("const_hsize", 32'(bus.HSIZE), 32'd2);
        chk("const_hburst", 32'(bus.HBURST), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Zero-wait, MODE 0 at 0x100; a START mid-test must be ignored
        base = wr_done;
        start_test(2'd0, 32'h100);
        chk("t1_first_htrans", 32'(bus.HTRANS), 32'h2);
        chk("t1_first_haddr", bus.HADDR, 32'h100);
        chk("t1_first_hwrite", 32'(bus.HWRITE), 32'd1);
        chk("t1_busy_write", 32'({S_BUSY, S_WRITE, S_CHECK}), 32'b110);
        run_to_done(2000, 20);
        chk("t1_write_cycles", 32'(wcyc), 32'd9);
        chk("t1_check_cycles", 32'(ccyc), 32'd34);
        chk("t1_errcount", ERRCOUNT, 32'd0);
        chk("t1_chkcount", 32'(CHKCOUNT), 32'd2);
        chk("t1_success", 32'({S_SUCCESS, S_FAILED, S_BUSY}), 32'b100);
        for (int i = 0; i < 8; i++) begin
            chk("t1_wr_addr", wlog_addr[(base + i) % 128], 32'h100 + 32'(4 * i));
            chk("t1_wr_data", wlog_data[(base + i) % 128], 32'h100 + 32'(4 * i));
        end

        // 50% random stalls, MODE 2
        base = wr_done;
        stall_pct = 50;
        start_test(2'd2, 32'h100);
        run_to_done(4000, -1);
        stall_pct = 0;
        chk("t2_errcount", ERRCOUNT, 32'd0);
        chk("t2_chkcount", 32'(CHKCOUNT), 32'd2);
        chk("t2_success", 32'(S_SUCCESS), 32'd1);
        chk("t2_stalls_seen", 32'(stall_seen > 0), 32'd1);
        chk("t2_wr_data0", wlog_data[base % 128], 32'hA5A5_0000);
        chk("t2_wr_data1", wlog_data[(base + 1) % 128], 32'h43DC_79B9);
        chk("t2_wr_data2", wlog_data[(base + 2) % 128], 32'hE213_F372);

        // Corrupt the first read of 0x108
        corrupt_addr = 32'h108;
        corrupt_req = corrupt_req + 1;
        start_test(2'd0, 32'h100);
        run_to_done(2000, -1);
        chk("t3_errcount", ERRCOUNT, 32'd1);
        chk("t3_ferr_addr", FIRSTERR_ADDR, 32'h108);
        chk("t3_ferr_data", FIRSTERR_DATA, 32'h0);
        chk("t3_chkcount", 32'(CHKCOUNT), 32'd2);
        chk("t3_failed", 32'({S_SUCCESS, S_FAILED}), 32'b01);

        // ERROR response on the third write (memory still holds 0x108 there)
        resp_at = wr_done + 2;
        start_test(2'd0, 32'h100);
        run_to_done(2000, -1);
        resp_at = -1;
        chk("t4_errcount", ERRCOUNT, 32'd1);
        chk("t4_ferr_addr", FIRSTERR_ADDR, 32'h108);
        chk("t4_failed", 32'(S_FAILED), 32'd1);

        // Corrupt the last word in both passes: final error lands on the drain exit
        corrupt_addr = 32'h11C;
        corrupt_req = corrupt_req + 2;
        start_test(2'd0, 32'h100);
        run_to_done(2000, -1);
        chk("t5_errcount", ERRCOUNT, 32'd2);
        chk("t5_ferr_addr", FIRSTERR_ADDR, 32'h11C);
        chk("t5_ferr_data", FIRSTERR_DATA, 32'h0);
        chk("t5_failed", 32'({S_SUCCESS, S_FAILED}), 32'b01);

        // Address wrap with walking-one pattern
        base = wr_done;
        start_test(2'd3, 32'hFFFF_FFF8);
        run_to_done(2000, -1);
        chk("t6_addr0", wlog_addr[base % 128], 32'hFFFF_FFF8);
        chk("t6_addr1", wlog_addr[(base + 1) % 128], 32'hFFFF_FFFC);
        chk("t6_addr2", wlog_addr[(base + 2) % 128], 32'h0);
        chk("t6_addr3", wlog_addr[(base + 3) % 128], 32'h4);
        chk("t6_data0", wlog_data[base % 128], 32'h1);
        chk("t6_data1", wlog_data[(base + 1) % 128], 32'h2);
        chk("t6_data2", wlog_data[(base + 2) % 128], 32'h4);
        chk("t6_data3", wlog_data[(base + 3) % 128], 32'h8);
        chk("t6_success", 32'({S_SUCCESS, S_FAILED}), 32'b10);
        chk("t6_errcount", ERRCOUNT, 32'd0);

        // Asynchronous reset during the second read sweep
        start_test(2'd1, 32'h100);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            if (S_CHECK && CHKCOUNT == 8'd1 && bus.HTRANS == 2'b10 && !bus.HWRITE) found = 1;
            else @(negedge HCLK);
        end
        chk("t7_in_read", 32'(found), 32'd1);
        #2 HRESET = 1'b1;
        #1;
        chk("t7_htrans", 32'(bus.HTRANS), 32'd0);
        chk("t7_haddr", bus.HADDR, 32'd0);
        chk("t7_hwrite", 32'(bus.HWRITE), 32'd0);
        chk("t7_hwdata", bus.HWDATA, 32'd0);
        chk("t7_chkcount", 32'(CHKCOUNT), 32'd0);
        chk("t7_flags", 32'({S_BUSY, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED}), 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        start_test(2'd1, 32'h100);
        run_to_done(2000, -1);
        chk("t7_rerun_success", 32'(S_SUCCESS), 32'd1);
        chk("t7_rerun_errcount", ERRCOUNT, 32'd0);
        chk("t7_rerun_chkcount", 32'(CHKCOUNT), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
